// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Optional refractory counters are compiled in with `define LIF_REFRACTORY_EN.
module lif_neuron_array #(
  parameter int N_NEURONS      = 4,
  parameter int WIDTH          = 8,
  parameter int BETA_SHIFT     = 1,
  parameter int THRESH_INIT    = 200,
  parameter int ADAPT_INC      = 8,
  parameter int REFRACT_SWEEPS = 2,
  localparam int ID_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 adaptive_threshold,
  input  logic                 adaptive_beta,
  input  logic                 cur_valid,
  output logic                 cur_ready,
  input  logic [ID_W-1:0]      cur_id,
  input  logic [WIDTH-1:0]     cur_data,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 spike_valid,
  output logic                 busy,
  input  logic [ID_W-1:0]      mon_sel,
  output logic [WIDTH-1:0]     mon_state,
  output logic [WIDTH-1:0]     mon_thresh
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} fsm_e;

  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0] TH_INIT  = WIDTH'(THRESH_INIT);

  fsm_e                 fsm_q, fsm_d;
  logic [ID_W-1:0]      idx_q, idx_d;
  logic                 at_q, at_d, ab_q, ab_d;
  logic [WIDTH-1:0]     state_q [N_NEURONS];
  logic [WIDTH-1:0]     state_d [N_NEURONS];
  logic [WIDTH-1:0]     thresh_q [N_NEURONS];
  logic [WIDTH-1:0]     thresh_d [N_NEURONS];
  logic [WIDTH-1:0]     pend_q [N_NEURONS];
  logic [WIDTH-1:0]     pend_d [N_NEURONS];
  logic [WIDTH-1:0]     act_q [N_NEURONS];
  logic [WIDTH-1:0]     act_d [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q, acc_d, spike_vec_q, spike_vec_d;
  logic                 spike_valid_q, spike_valid_d;
  logic [WIDTH-1:0]     mon_state_q, mon_state_d, mon_thresh_q, mon_thresh_d;
`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT_SWEEPS + 1);
  logic [RW-1:0]        ref_q [N_NEURONS];
  logic [RW-1:0]        ref_d [N_NEURONS];
`endif

  logic [WIDTH-1:0] cur_st, cur_th, cur_cu, leak, v_sat, th_inc;
  logic [WIDTH:0]   v_raw, th_sum;
  logic             fire, wr_ok, mon_ok;

  assign busy        = (fsm_q != S_IDLE);
  assign cur_ready   = (fsm_q != S_LOAD);
  assign spike_vec   = spike_vec_q;
  assign spike_valid = spike_valid_q;
  assign mon_state   = mon_state_q;
  assign mon_thresh  = mon_thresh_q;
  assign wr_ok       = cur_valid && cur_ready && (int'(cur_id) < N_NEURONS);
  assign mon_ok      = (int'(mon_sel) < N_NEURONS);

  // Shared datapath: one neuron per cycle, selected by idx_q.
  always_comb begin
    cur_st = state_q[idx_q];
    cur_th = thresh_q[idx_q];
    cur_cu = act_q[idx_q];
    if (ab_q && (cur_st >= (cur_th >> 1))) leak = cur_st >> (BETA_SHIFT + 1);
    else                                    leak = cur_st >> BETA_SHIFT;
    v_raw  = {1'b0, cur_st} - {1'b0, leak} + {1'b0, cur_cu};
    v_sat  = v_raw[WIDTH] ? '1 : v_raw[WIDTH-1:0];
    fire   = (v_sat >= cur_th);
    th_sum = {1'b0, cur_th} + (WIDTH+1)'(ADAPT_INC);
    th_inc = th_sum[WIDTH] ? '1 : th_sum[WIDTH-1:0];
  end

  always_comb begin
    fsm_d         = fsm_q;
    idx_d         = idx_q;
    at_d          = at_q;
    ab_d          = ab_q;
    state_d       = state_q;
    thresh_d      = thresh_q;
    pend_d        = pend_q;
    act_d         = act_q;
    acc_d         = acc_q;
    spike_vec_d   = spike_vec_q;
    spike_valid_d = 1'b0;
`ifdef LIF_REFRACTORY_EN
    ref_d         = ref_q;
`endif
    if (wr_ok) pend_d[cur_id] = cur_data;
    case (fsm_q)
      S_IDLE: if (en) fsm_d = S_LOAD;
      S_LOAD: begin
        act_d = pend_q;
        at_d  = adaptive_threshold;
        ab_d  = adaptive_beta;
        idx_d = '0;
        acc_d = '0;
        if (!adaptive_threshold)
          for (int i = 0; i < N_NEURONS; i++) thresh_d[i] = TH_INIT;
        fsm_d = S_UPDATE;
      end
      S_UPDATE: begin
`ifdef LIF_REFRACTORY_EN
        if (ref_q[idx_q] != '0) begin
          state_d[idx_q] = '0;
          ref_d[idx_q]   = ref_q[idx_q] - RW'(1);
        end else
`endif
        if (fire) begin
          state_d[idx_q] = '0;
          acc_d[idx_q]   = 1'b1;
          if (at_q) thresh_d[idx_q] = th_inc;
`ifdef LIF_REFRACTORY_EN
          ref_d[idx_q] = RW'(REFRACT_SWEEPS);
`endif
        end else begin
          state_d[idx_q] = v_sat;
        end
        if (idx_q == LAST_IDX) fsm_d = S_DONE;
        else                   idx_d = idx_q + ID_W'(1);
      end
      S_DONE: begin
        spike_vec_d   = acc_q;
        spike_valid_d = 1'b1;
        // Adapted thresholds relax by one step per sweep without a spike.
        if (at_q)
          for (int i = 0; i < N_NEURONS; i++)
            if (!acc_q[i] && (thresh_q[i] > TH_INIT)) thresh_d[i] = thresh_q[i] - WIDTH'(1);
        fsm_d = en ? S_LOAD : S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    mon_state_d  = mon_ok ? state_q[mon_sel]  : '0;
    mon_thresh_d = mon_ok ? thresh_q[mon_sel] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= S_IDLE;
      idx_q         <= '0;
      at_q          <= 1'b0;
      ab_q          <= 1'b0;
      acc_q         <= '0;
      spike_vec_q   <= '0;
      spike_valid_q <= 1'b0;
      mon_state_q   <= '0;
      mon_thresh_q  <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= '0;
        thresh_q[i] <= TH_INIT;
        pend_q[i]   <= '0;
        act_q[i]    <= '0;
`ifdef LIF_REFRACTORY_EN
        ref_q[i]    <= '0;
`endif
      end
    end else begin
      fsm_q         <= fsm_d;
      idx_q         <= idx_d;
      at_q          <= at_d;
      ab_q          <= ab_d;
      acc_q         <= acc_d;
      spike_vec_q   <= spike_vec_d;
      spike_valid_q <= spike_valid_d;
      mon_state_q   <= mon_state_d;
      mon_thresh_q  <= mon_thresh_d;
      state_q       <= state_d;
      thresh_q      <= thresh_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
`ifdef LIF_REFRACTORY_EN
      ref_q         <= ref_d;
`endif
    end
  end

endmodule
